rx_sequencer: RTL and testbench

UART receive sequencer: watches the serial line, aligns bit sampling to the oversampling tick from the baud unit, and emits a mid-bit shift strobe for the receiver datapath. It assembles each frame into a byte, checks framing, and hands the byte to the host through a one-entry valid/ready holding register. It sits between the baud unit, the receiver and the consuming logic, and owns the bit timing for the receive path.

---
 rtl/rx_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_rx_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sequencer.sv
// -----------------------------------------------------------------------------
// rx_sequencer
//
// UART receive sequencer. Synchronizes the raw serial line, aligns bit sampling
// to the oversampling tick from the baud unit, emits a mid-bit shift strobe,
// assembles each frame into a byte, checks framing (and optionally parity) and
// hands the byte to the consumer through a one-entry holding register.
//
// Optional feature macro: RX_SEQUENCER_PARITY_EN
//   defined   -> frame is start + WIDTH data + even parity + stop, and the
//                parity_err port exists.
//   undefined -> frame is start + WIDTH data + stop, no parity_err port.
//
// Parameters
//   WIDTH       data bits per frame, LSB first (at least 2)
//   OVERSAMPLE  sample_tick pulses per bit period (even, at least 4)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   rxd           raw serial line, idles high, asynchronous to clk
//   sample_tick   one-cycle pulse at OVERSAMPLE x baud
//   baud_restart  one-cycle pulse resyncing the baud unit on a start edge
//   bit_strobe    one-cycle pulse after each data-bit mid-sample
//   busy          high whenever the sequencer is not idle
//   rx_data       held byte, stable while rx_valid is high
//   rx_valid      held byte available
//   rx_ready      consumer accepts the held byte
//   frame_err     one-cycle pulse: stop bit sampled low
//   overrun       one-cycle pulse: completed byte dropped, holder full
//   parity_err    one-cycle pulse: parity mismatch (parity build only)
//   state_dbg     current FSM state encoding, for observation
//
// Handshake: a transfer happens on every rising clk edge where
// rx_valid & rx_ready are both high. rx_valid never drops without a transfer,
// and rx_data does not change while rx_valid is high unless that same edge is
// a transfer that also loads a newly completed byte.
// -----------------------------------------------------------------------------
module rx_sequencer #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxd,
  input  logic             sample_tick,
  output logic             baud_restart,
  output logic             bit_strobe,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
`ifdef RX_SEQUENCER_PARITY_EN
  output logic             parity_err,
`endif
  output logic [2:0]       state_dbg
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state;
  state_t state_n;

  // Synchronizer and edge history; all reset high so a released reset with an
  // idle line never looks like a start edge.
  logic sync_q;
  logic rxs;
  logic rxs_prev;

  logic [CW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_q;

  logic fall_edge;
  logic tick_last;
  logic tick_half;
  logic bit_last;
  logic tick_wrap;

  logic restart_n;
  logic strobe_n;
  logic ferr_n;
  logic data_sample;
  logic stop_sample;
  logic complete;
  logic load;
  logic ovr_n;
  logic par_ok;

`ifdef RX_SEQUENCER_PARITY_EN
  logic par_q;
  logic par_sample;
  logic perr_n;
`endif

  assign fall_edge = rxs_prev & ~rxs;
  assign tick_last = (tick_cnt == CW'(OVERSAMPLE - 1));
  assign tick_half = (tick_cnt == CW'(OVERSAMPLE / 2 - 1));
  assign bit_last  = (bit_cnt == BW'(WIDTH - 1));
  // START only waits half a bit to land on the middle of the start bit;
  // every later state waits a full bit from there.
  assign tick_wrap = tick_last | ((state == S_START) & tick_half);

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

`ifdef RX_SEQUENCER_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_ok = ~^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  // A completed byte is taken if the holder is empty or is being emptied on
  // this same edge; otherwise the new byte is the one that gets dropped.
  assign load  = complete & (~rx_valid | rx_ready);
  assign ovr_n = complete & rx_valid & ~rx_ready;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync_q   <= rxd;
      rxs      <= sync_q;
      rxs_prev <= rxs;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (fall_edge) state_n = S_START;
      end
      S_START: begin
        // Line back high at mid start bit is a glitch, not a frame.
        if (sample_tick && tick_half) state_n = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample_tick && tick_last && bit_last) begin
`ifdef RX_SEQUENCER_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef RX_SEQUENCER_PARITY_EN
      S_PARITY: begin
        if (sample_tick && tick_last) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (sample_tick && tick_last) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (registered one cycle later in the datapath block)
  // ---------------------------------------------------------------------------
  always_comb begin
    restart_n   = 1'b0;
    data_sample = 1'b0;
    stop_sample = 1'b0;
    ferr_n      = 1'b0;
    complete    = 1'b0;
`ifdef RX_SEQUENCER_PARITY_EN
    par_sample  = 1'b0;
    perr_n      = 1'b0;
`endif
    case (state)
      S_IDLE:   restart_n   = fall_edge;
      S_DATA:   data_sample = sample_tick & tick_last;
`ifdef RX_SEQUENCER_PARITY_EN
      S_PARITY: par_sample  = sample_tick & tick_last;
`endif
      S_STOP:   stop_sample = sample_tick & tick_last;
      default: ;
    endcase
    strobe_n = data_sample;
    if (stop_sample) begin
      if (!rxs) begin
        ferr_n = 1'b1;
      end else if (!par_ok) begin
`ifdef RX_SEQUENCER_PARITY_EN
        perr_n = 1'b1;
`endif
      end else begin
        complete = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, shift register, holding register, output pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      baud_restart <= 1'b0;
      bit_strobe   <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      baud_restart <= restart_n;
      bit_strobe   <= strobe_n;
      frame_err    <= ferr_n;
      overrun      <= ovr_n;

      // Held at zero while idle, so the counter starts from 0 at the start
      // edge and ticks arriving while idle have no effect.
      if (state == S_IDLE) begin
        tick_cnt <= '0;
      end else if (sample_tick) begin
        tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
      end

      if (state == S_START) begin
        bit_cnt <= '0;
      end else if (data_sample) begin
        bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
      end

      // LSB arrives first, so after WIDTH shifts it sits in bit 0.
      if (data_sample) begin
        shift_q <= {rxs, shift_q[WIDTH-1:1]};
      end

      if (load) begin
        rx_data <= shift_q;
      end

      if (load) begin
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef RX_SEQUENCER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= perr_n;
      if (par_sample) begin
        par_q <= rxs;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rx_sequencer
//
// Drives serial frames at 64 clk per bit (sample_tick every 4th clk,
// OVERSAMPLE=16) and compares the sequencer's outputs against a frame-level
// reference model: per frame the model knows how many strobes, restarts and
// error pulses must appear and which bytes must reach the consumer.
// -----------------------------------------------------------------------------
module tb_rx_sequencer;

  localparam int W       = 8;
  localparam int OS      = 16;
  localparam int BIT_CLK = 64;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk         = 1'b0;
  logic         reset       = 1'b0;
  logic         rxd         = 1'b1;
  logic         sample_tick = 1'b0;
  logic         rx_ready    = 1'b0;
  logic         baud_restart;
  logic         bit_strobe;
  logic         busy;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         overrun;
  logic [2:0]   state_dbg;
`ifdef RX_SEQUENCER_PARITY_EN
  logic         parity_err;
`endif

  always #5 clk = ~clk;

  rx_sequencer #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .reset        (reset),
    .rxd          (rxd),
    .sample_tick  (sample_tick),
    .baud_restart (baud_restart),
    .bit_strobe   (bit_strobe),
    .busy         (busy),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun),
`ifdef RX_SEQUENCER_PARITY_EN
    .parity_err   (parity_err),
`endif
    .state_dbg    (state_dbg)
  );

  // Free-running baud tick: one pulse every 4th clk, driven just after posedge.
  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 4;
      sample_tick = (div == 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state and checker
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  int cnt_restart = 0, cnt_strobe = 0, cnt_ferr = 0, cnt_ovr = 0, cnt_perr = 0;
  int exp_restart = 0, exp_strobe = 0, exp_ferr = 0, exp_ovr = 0, exp_perr = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit           m_held = 1'b0;
  logic [W-1:0] m_data = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (baud_restart) cnt_restart++;
      if (bit_strobe)   cnt_strobe++;
      if (frame_err)    cnt_ferr++;
      if (overrun)      cnt_ovr++;
`ifdef RX_SEQUENCER_PARITY_EN
      if (parity_err)   cnt_perr++;
`endif
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_data(input logic [W-1:0] d);
    rxd = 1'b0;
    step(BIT_CLK);
    for (int i = 0; i < W; i++) begin
      rxd = d[i];
      step(BIT_CLK);
    end
  endtask

`ifdef RX_SEQUENCER_PARITY_EN
  task automatic send_raw(input logic [W-1:0] d, input logic stop, input logic par);
    send_data(d);
    rxd = par;
    step(BIT_CLK);
    rxd = stop;
    step(BIT_CLK);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop);
    send_raw(d, stop, ^d);
  endtask
`else
  task automatic send_frame(input logic [W-1:0] d, input logic stop);
    send_data(d);
    rxd = stop;
    step(BIT_CLK);
  endtask
`endif

  // Consumer readiness; raising it while a byte is held moves that byte out.
  task automatic set_ready(input logic b);
    rx_ready = b;
    if (b && m_held) begin
      exp_q.push_back(m_data);
      m_held = 1'b0;
    end
  endtask

  task automatic drain;
    set_ready(1'b1);
    step(1);
    set_ready(1'b0);
    step(4);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: outcome of one complete frame
  // ---------------------------------------------------------------------------
  task automatic model_frame(input logic [W-1:0] d, input bit stop_ok, input bit par_ok);
    exp_restart++;
    exp_strobe += W;
    if (!stop_ok) begin
      exp_ferr++;
    end else if (!par_ok) begin
      exp_perr++;
    end else if (m_held) begin
      exp_ovr++;
    end else begin
      m_held = 1'b1;
      m_data = d;
    end
    if (rx_ready && m_held) begin
      exp_q.push_back(m_data);
      m_held = 1'b0;
    end
  endtask

  task automatic check_all(input string pfx);
    check_val({pfx, "_restart"}, cnt_restart, exp_restart);
    check_val({pfx, "_strobe"},  cnt_strobe,  exp_strobe);
    check_val({pfx, "_frame_err"}, cnt_ferr,  exp_ferr);
    check_val({pfx, "_overrun"}, cnt_ovr,     exp_ovr);
    check_val({pfx, "_parity_err"}, cnt_perr, exp_perr);
    check_val({pfx, "_busy"},    busy,        1'b0);
    check_val({pfx, "_rx_valid"}, rx_valid,   m_held);
    if (m_held) check_val({pfx, "_rx_data"}, rx_data, m_data);
    check_val({pfx, "_xfer_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check_val({pfx, "_xfer_data"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : main
    logic [W-1:0] d;
    logic         stop;
    bit           good;

    // Reset state
    reset = 1'b0;
    step(5);
    check_val("rst_baud_restart", baud_restart, 1'b0);
    check_val("rst_bit_strobe",   bit_strobe,   1'b0);
    check_val("rst_busy",         busy,         1'b0);
    check_val("rst_rx_valid",     rx_valid,     1'b0);
    check_val("rst_rx_data",      rx_data,      '0);
    check_val("rst_frame_err",    frame_err,    1'b0);
    check_val("rst_overrun",      overrun,      1'b0);
    reset = 1'b1;
    step(200);
    check_all("idle");

    // Good frame, consumer not ready: byte held
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b1);
    step(8);
    check_all("a5");
    drain();
    check_all("a5_drain");

    // Stop bit low: frame error, line left low must not retrigger
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b1);
    step(8);
    check_all("ferr");
    step(200);
    check_val("ferr_low_line_busy", busy, 1'b0);
    check_val("ferr_low_line_restart", cnt_restart, exp_restart);
    rxd = 1'b1;
    step(100);

    // False start: low for well under half a bit
    rxd = 1'b0;
    step(20);
    rxd = 1'b1;
    step(100);
    exp_restart++;
    check_all("false_start");

    // Back-to-back frames into a full holder
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1, 1'b1);
    step(8);
    check_all("overrun");
    drain();
    check_all("overrun_drain");

    // Reset in the first quarter of data bit 4 of a 0x77 frame
    rxd = 1'b0;
    step(BIT_CLK);
    d = 8'h77;
    for (int i = 0; i < 4; i++) begin
      rxd = d[i];
      step(BIT_CLK);
    end
    step(8);
    reset = 1'b0;
    exp_restart++;
    exp_strobe += 4;
    m_held = 1'b0;
    step(2);
    check_val("mid_rst_busy",       busy,       1'b0);
    check_val("mid_rst_rx_valid",   rx_valid,   1'b0);
    check_val("mid_rst_rx_data",    rx_data,    '0);
    check_val("mid_rst_bit_strobe", bit_strobe, 1'b0);
    check_val("mid_rst_frame_err",  frame_err,  1'b0);
    rxd = 1'b1;
    step(4);
    reset = 1'b1;
    step(20);
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1, 1'b1);
    step(8);
    check_all("after_rst");
    drain();
    check_all("after_rst_drain");

`ifdef RX_SEQUENCER_PARITY_EN
    // 0x07 has three ones, so even parity needs parity bit 1
    send_raw(8'h07, 1'b1, 1'b0);
    model_frame(8'h07, 1'b1, 1'b0);
    step(8);
    check_all("par_bad");
    send_raw(8'h07, 1'b1, 1'b1);
    model_frame(8'h07, 1'b1, 1'b1);
    step(8);
    check_all("par_good");
    drain();
    check_all("par_drain");
`endif

    // Randomized frames, stop errors and consumer readiness
    for (int n = 0; n < 16; n++) begin
      d    = W'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      good = 1'b1;
      set_ready(logic'($urandom_range(0, 1)));
      step($urandom_range(4, 40));
`ifdef RX_SEQUENCER_PARITY_EN
      good = ($urandom_range(0, 3) != 0);
      send_raw(d, stop, good ? ^d : ~^d);
`else
      send_frame(d, stop);
`endif
      model_frame(d, stop, good);
      rxd = 1'b1;
      step(8);
      check_all("rand");
    end
    set_ready(1'b1);
    step(4);
    set_ready(1'b0);
    step(4);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
